solo_squash_input_conditioner: RTL and testbench

SOLO_SQUASH_INPUT_CONDITIONER -- requirements
Module: solo_squash_input_conditioner

---
 rtl/solo_squash_pkg.sv | 11 +
 rtl/solo_squash_debounce_channel.sv | 53 +++++
 rtl/solo_squash_input_conditioner.sv | 42 ++++
 tb/tb_solo_squash_input_conditioner.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/solo_squash_pkg.sv
// Shared constants for the solo squash key conditioning path.
package solo_squash_pkg;

  localparam int NUM_KEYS     = 4;

  localparam int KEY_PAUSE    = 0;
  localparam int KEY_NEW_GAME = 1;
  localparam int KEY_DOWN     = 2;
  localparam int KEY_UP       = 3;

endpackage

// File: rtl/solo_squash_debounce_channel.sv
// One key channel: synchroniser chain, stability counter, debounced level
// and one-cycle press/release pulses. Everything is active-low on the pad side.
module solo_squash_debounce_channel #(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic raw_n,
  output logic level_n,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);
  // The edge that sees this count with synced still different is the one
  // that accepts the change, so the counter never reaches DEBOUNCE_LIMIT.
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          count_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Synchronise, count stable cycles, update the level and emit pulses.
  // Gating by enable mirrors reset so that forcing the level high never pulses.
  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      sync_q        <= '1;
      count_q       <= '0;
      level_n       <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], raw_n};
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (synced == level_n) begin
        count_q <= '0;
      end else if (count_q == LAST) begin
        count_q       <= '0;
        level_n       <= synced;
        press_pulse   <= ~synced;
        release_pulse <= synced;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/solo_squash_input_conditioner.sv
// Conditions the four active-low game keys between the pads and the core:
// synchronises, debounces and produces press/release pulses per key.
module solo_squash_input_conditioner
  import solo_squash_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic                wb_clk_i,
  input  logic                reset_n,
  input  logic                gpio_ready,
  input  logic [NUM_KEYS-1:0] keys_raw_n,
  output logic [NUM_KEYS-1:0] keys_n,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  logic [NUM_KEYS-1:0] level_n;
  logic [NUM_KEYS-1:0] press_pulse;
  logic [NUM_KEYS-1:0] release_pulse;

  // Independent channel per key; outputs come straight from channel flops.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    solo_squash_debounce_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_channel (
      .clk          (wb_clk_i),
      .reset_n      (reset_n),
      .enable       (gpio_ready),
      .raw_n        (keys_raw_n[i]),
      .level_n      (level_n[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end

  assign keys_n      = level_n;
  assign key_press   = press_pulse;
  assign key_release = release_pulse;

endmodule

// File: tb/tb_solo_squash_input_conditioner.sv
// Directed bench for the key conditioner with SYNC_STAGES=2, DEBOUNCE_LIMIT=8,
// so an accepted change lands 10 clock edges after the raw edge.
module tb_solo_squash_input_conditioner;
  import solo_squash_pkg::*;

  logic       wb_clk_i = 1'b0;
  logic       reset_n;
  logic       gpio_ready;
  logic [3:0] keys_raw_n;
  logic [3:0] keys_n;
  logic [3:0] key_press;
  logic [3:0] key_release;

  int checks = 0;
  int errors = 0;

  logic [3:0] seen_p;
  logic [3:0] seen_r;
  logic [3:0] pulse_cnt;

  solo_squash_input_conditioner #(
    .SYNC_STAGES   (2),
    .DEBOUNCE_LIMIT(8)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .reset_n    (reset_n),
    .gpio_ready (gpio_ready),
    .keys_raw_n (keys_raw_n),
    .keys_n     (keys_n),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // One rising edge, then return to the falling edge for driving/sampling.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_seen();
    seen_p = 4'b0000;
    seen_r = 4'b0000;
  endtask

  task automatic cyc_track(input int n);
    repeat (n) begin
      cyc();
      seen_p |= key_press;
      seen_r |= key_release;
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    gpio_ready = 1'b1;
    keys_raw_n = 4'b1111;
    clear_seen();
    pulse_cnt  = 4'd0;
    @(negedge wb_clk_i);
    cyc(2);
    chk("reset_keys_n", keys_n, 4'b1111);
    chk("reset_press", key_press, 4'b0000);
    chk("reset_release", key_release, 4'b0000);
    reset_n = 1'b1;
    cyc(3);

    // Clean press on the up key: exact 10-edge latency, single pulse.
    keys_raw_n[KEY_UP] = 1'b0;
    clear_seen();
    cyc_track(9);
    chk("clean_before_keys_n", keys_n, 4'b1111);
    chk("clean_before_pulses", seen_p | seen_r, 4'b0000);
    cyc();
    chk("clean_keys_n", keys_n, 4'b0111);
    chk("clean_press", key_press, 4'b1000);
    chk("clean_release", key_release, 4'b0000);
    cyc();
    chk("clean_press_end", key_press, 4'b0000);
    chk("clean_hold_keys_n", keys_n, 4'b0111);

    // Press the down key as well, then release both together.
    keys_raw_n[KEY_DOWN] = 1'b0;
    cyc(10);
    chk("down_keys_n", keys_n, 4'b0011);
    chk("down_press", key_press, 4'b0100);
    cyc();
    keys_raw_n[KEY_DOWN] = 1'b1;
    keys_raw_n[KEY_UP]   = 1'b1;
    cyc(9);
    chk("simul_before", keys_n, 4'b0011);
    cyc();
    chk("simul_release", key_release, 4'b1100);
    chk("simul_keys_n", keys_n, 4'b1111);
    chk("simul_no_press", key_press, 4'b0000);
    cyc();
    chk("simul_release_end", key_release, 4'b0000);

    // Bounce on pause: 5 low, 1 high, then held low.
    keys_raw_n[KEY_PAUSE] = 1'b0;
    cyc(5);
    keys_raw_n[KEY_PAUSE] = 1'b1;
    cyc(1);
    keys_raw_n[KEY_PAUSE] = 1'b0;
    pulse_cnt = 4'd0;
    repeat (9) begin
      cyc();
      pulse_cnt += {3'b000, key_press[KEY_PAUSE]};
    end
    chk("bounce_before", keys_n, 4'b1111);
    cyc();
    pulse_cnt += {3'b000, key_press[KEY_PAUSE]};
    chk("bounce_keys_n", keys_n, 4'b1110);
    repeat (5) begin
      cyc();
      pulse_cnt += {3'b000, key_press[KEY_PAUSE]};
    end
    chk("bounce_pulse_count", pulse_cnt, 4'd1);
    keys_raw_n[KEY_PAUSE] = 1'b1;
    cyc(12);
    chk("bounce_released", keys_n, 4'b1111);

    // Glitch shorter than the window on new_game is rejected.
    clear_seen();
    keys_raw_n[KEY_NEW_GAME] = 1'b0;
    cyc_track(7);
    keys_raw_n[KEY_NEW_GAME] = 1'b1;
    cyc_track(12);
    chk("glitch_keys_n", keys_n, 4'b1111);
    chk("glitch_pulses", seen_p | seen_r, 4'b0000);

    // Reset in the middle of a count discards it; held key is re-accepted.
    keys_raw_n[KEY_DOWN] = 1'b0;
    cyc(6);
    reset_n = 1'b0;
    cyc(1);
    chk("rst_mid_keys_n", keys_n, 4'b1111);
    chk("rst_mid_pulses", key_press | key_release, 4'b0000);
    reset_n = 1'b1;
    clear_seen();
    cyc_track(9);
    chk("rst_rel_before", keys_n, 4'b1111);
    chk("rst_rel_no_pulse", seen_p | seen_r, 4'b0000);
    cyc();
    chk("rst_rel_keys_n", keys_n, 4'b1011);
    chk("rst_rel_press", key_press, 4'b0100);
    keys_raw_n[KEY_DOWN] = 1'b1;
    cyc(12);
    chk("rst_key_up", keys_n, 4'b1111);

    // gpio_ready gating: forcing a pressed key high must not pulse.
    keys_raw_n[KEY_PAUSE] = 1'b0;
    cyc(11);
    chk("gate_pre_keys_n", keys_n, 4'b1110);
    gpio_ready = 1'b0;
    keys_raw_n = 4'b0000;
    clear_seen();
    cyc_track(12);
    chk("gate_keys_n", keys_n, 4'b1111);
    chk("gate_no_pulses", seen_p | seen_r, 4'b0000);
    gpio_ready = 1'b1;
    clear_seen();
    cyc_track(9);
    chk("gate_rise_before", keys_n, 4'b1111);
    chk("gate_rise_no_pulse", seen_p | seen_r, 4'b0000);
    cyc();
    chk("gate_rise_press", key_press, 4'b1111);
    chk("gate_rise_keys_n", keys_n, 4'b0000);
    cyc();
    chk("gate_rise_press_end", key_press, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
